sqrt_issue_ctrl: RTL and testbench

Single-outstanding initiator that drives the `sqrt` unit's `in_valid`/`in_ready`/`out_valid`/`cancel` interface on behalf of a host-side valid/ready request channel. It latches one operand and rounding mode, issues it to the unit, and holds the rounding mode stable for the whole operation. It captures the unit's one-cycle `out_valid` pulse into a backpressurable response register, and cancels the unit on a watchdog timeout or a host abort. It sits between the user-project register/bus logic and the `sqrt` instance.

---
 rtl/sqrt_issue_ctrl_if.sv | 44 ++++
 rtl/sqrt_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_sqrt_issue_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_issue_ctrl_if.sv
// Bundles for the sqrt issue controller: the host request/response channel
// and the link to the sqrt unit.
interface sqrt_host_if #(parameter int W = 32);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_operand;
    logic [2:0]   req_round_mode;
    logic         abort;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [4:0]   rsp_exceptions;
    logic         rsp_timeout;
    logic         busy;

    modport master (
        output req_valid, req_operand, req_round_mode, abort, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_exceptions, rsp_timeout, busy
    );
    modport slave (
        input  req_valid, req_operand, req_round_mode, abort, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_exceptions, rsp_timeout, busy
    );
endinterface

interface sqrt_fpu_if #(parameter int W = 32);
    logic         fpu_in_valid;
    logic         fpu_in_ready;
    logic [W-1:0] fpu_a;
    logic [2:0]   fpu_round_mode;
    logic         fpu_cancel;
    logic         fpu_out_valid;
    logic [W-1:0] fpu_out;
    logic [4:0]   fpu_exceptions;

    modport master (
        output fpu_in_valid, fpu_a, fpu_round_mode, fpu_cancel,
        input  fpu_in_ready, fpu_out_valid, fpu_out, fpu_exceptions
    );
    modport slave (
        input  fpu_in_valid, fpu_a, fpu_round_mode, fpu_cancel,
        output fpu_in_ready, fpu_out_valid, fpu_out, fpu_exceptions
    );
endinterface

// File: rtl/sqrt_issue_ctrl.sv
// Single-outstanding issue controller for the sqrt unit: latches one request,
// issues it, captures the result pulse, and cancels on watchdog or host abort.
//
// state | meaning
// IDLE  | waiting for a host request
// ISSUE | fpu_in_valid high until the unit accepts
// WAIT  | operation in flight, watchdog running
// RESP  | response held until the host takes it
module sqrt_issue_ctrl #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 24,
    parameter int TIMEOUT    = 64
) (
    input logic              clk,
    input logic              rst,
    sqrt_host_if.slave       host,
    sqrt_fpu_if.master       fpu
);
    localparam int W = EXP_WIDTH + MANT_WIDTH;
    localparam logic [7:0]   TC_LOAD = 8'(TIMEOUT - 1);
    localparam logic [W-1:0] QNAN    = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-2){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t       state_q, state_d;
    logic [7:0]   timer_q;
    logic [W-1:0] op_q;
    logic [2:0]   rm_q;
    logic [W-1:0] rsp_result_q;
    logic [4:0]   rsp_exc_q;
    logic         rsp_timeout_q;

    logic accept, tmr_load, cap_res, cap_to, cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            op_q          <= '0;
            rm_q          <= '0;
            rsp_result_q  <= '0;
            rsp_exc_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= host.req_operand;
                rm_q <= host.req_round_mode;
            end
            // Watchdog counts down from TIMEOUT-1; zero marks the TIMEOUT-th WAIT cycle.
            if (tmr_load)
                timer_q <= TC_LOAD;
            else if (state_q == WAIT && timer_q != 8'd0)
                timer_q <= timer_q - 8'd1;
            if (cap_res) begin
                rsp_result_q  <= fpu.fpu_out;
                rsp_exc_q     <= fpu.fpu_exceptions;
                rsp_timeout_q <= 1'b0;
            end else if (cap_to) begin
                rsp_result_q  <= QNAN;
                rsp_exc_q     <= '0;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        tmr_load = 1'b0;
        cap_res  = 1'b0;
        cap_to   = 1'b0;
        cancel   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!host.abort && host.req_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (host.abort) begin
                    cancel  = 1'b1;
                    state_d = IDLE;
                end else if (fpu.fpu_in_ready) begin
                    tmr_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // A result on the terminal cycle beats the watchdog.
                if (host.abort) begin
                    cancel  = 1'b1;
                    state_d = IDLE;
                end else if (fpu.fpu_out_valid) begin
                    cap_res = 1'b1;
                    state_d = RESP;
                end else if (timer_q == 8'd0) begin
                    cancel  = 1'b1;
                    cap_to  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (host.abort || host.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign host.req_ready      = (state_q == IDLE) && !host.abort;
    assign host.busy           = (state_q != IDLE);
    assign host.rsp_valid      = (state_q == RESP);
    assign host.rsp_result     = rsp_result_q;
    assign host.rsp_exceptions = rsp_exc_q;
    assign host.rsp_timeout    = rsp_timeout_q;

    assign fpu.fpu_in_valid    = (state_q == ISSUE);
    assign fpu.fpu_a           = op_q;
    assign fpu.fpu_round_mode  = rm_q;
    assign fpu.fpu_cancel      = cancel;
endmodule

// File: tb/tb_sqrt_issue_ctrl.sv
// Directed bench for sqrt_issue_ctrl; the bench plays both host and sqrt unit.
module tb_sqrt_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_accept = 0;
    int   cancel_cycles;
    int   first_cancel;

    always #5 clk = ~clk;

    sqrt_host_if #(.W(32)) host();
    sqrt_fpu_if  #(.W(32)) fpu();

    sqrt_issue_ctrl #(.EXP_WIDTH(8), .MANT_WIDTH(24), .TIMEOUT(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (host),
        .fpu  (fpu)
    );

    always @(posedge clk) if (fpu.fpu_in_valid && fpu.fpu_in_ready) n_accept++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Request handshake, then unit acceptance; returns in WAIT cycle 1.
    task automatic issue(input logic [31:0] op, input logic [2:0] rm);
        host.req_valid      = 1'b1;
        host.req_operand    = op;
        host.req_round_mode = rm;
        step;
        host.req_valid      = 1'b0;
        host.req_operand    = 32'hDEADBEEF;
        host.req_round_mode = 3'd7;
        #1;
        chk("issue_in_valid", 32'(fpu.fpu_in_valid), 32'd1);
        chk("issue_fpu_a", fpu.fpu_a, op);
        chk("issue_fpu_rm", 32'(fpu.fpu_round_mode), 32'(rm));
        fpu.fpu_in_ready = 1'b1;
        step;
        fpu.fpu_in_ready = 1'b0;
    endtask

    // Unit result pulse after `waits` further WAIT cycles; checks the captured response.
    task automatic pulse(input int waits, input logic [31:0] res, input logic [4:0] exc);
        repeat (waits) step;
        fpu.fpu_out_valid  = 1'b1;
        fpu.fpu_out        = res;
        fpu.fpu_exceptions = exc;
        #1;
        chk("pulse_no_cancel", 32'(fpu.fpu_cancel), 32'd0);
        chk("pulse_no_rsp_yet", 32'(host.rsp_valid), 32'd0);
        step;
        fpu.fpu_out_valid  = 1'b0;
        fpu.fpu_out        = 32'h12345678;
        fpu.fpu_exceptions = 5'h1F;
        #1;
        chk("rsp_valid", 32'(host.rsp_valid), 32'd1);
        chk("rsp_result", host.rsp_result, res);
        chk("rsp_exceptions", 32'(host.rsp_exceptions), 32'(exc));
        chk("rsp_timeout", 32'(host.rsp_timeout), 32'd0);
    endtask

    task automatic retire;
        host.rsp_ready = 1'b1;
        step;
        host.rsp_ready = 1'b0;
        #1;
        chk("retire_req_ready", 32'(host.req_ready), 32'd1);
        chk("retire_rsp_valid", 32'(host.rsp_valid), 32'd0);
        chk("retire_busy", 32'(host.busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int a0;
        host.req_valid = 1'b0; host.req_operand = '0; host.req_round_mode = '0;
        host.abort = 1'b0; host.rsp_ready = 1'b0;
        fpu.fpu_in_ready = 1'b0; fpu.fpu_out_valid = 1'b0;
        fpu.fpu_out = '0; fpu.fpu_exceptions = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(host.req_ready), 32'd1);
        chk("rst_busy", 32'(host.busy), 32'd0);
        chk("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
        chk("rst_rsp_result", host.rsp_result, 32'h0);
        chk("rst_rsp_exc", 32'(host.rsp_exceptions), 32'd0);
        chk("rst_rsp_timeout", 32'(host.rsp_timeout), 32'd0);
        chk("rst_in_valid", 32'(fpu.fpu_in_valid), 32'd0);
        chk("rst_cancel", 32'(fpu.fpu_cancel), 32'd0);
        chk("rst_fpu_a", fpu.fpu_a, 32'h0);
        chk("rst_fpu_rm", 32'(fpu.fpu_round_mode), 32'd0);

        // sqrt(4.0), RNE
        step;
        a0 = n_accept;
        issue(32'h40800000, 3'd0);
        pulse(5, 32'h40000000, 5'b00000);
        chk("single_accept", 32'(n_accept - a0), 32'd1);
        retire;

        // sqrt(2.0), RNE
        issue(32'h40000000, 3'd0);
        pulse(20, 32'h3FB504F3, 5'b00001);
        retire;

        // sqrt(2.0), RTZ with host-side mode toggling during WAIT
        issue(32'h40000000, 3'd1);
        for (int i = 0; i < 4; i++) begin
            host.req_round_mode = (i % 2 == 0) ? 3'd0 : 3'd4;
            #1;
            chk("rtz_fpu_rm_stable", 32'(fpu.fpu_round_mode), 32'd1);
            step;
        end
        pulse(0, 32'h3FB504F3, 5'b00001);
        chk("rtz_fpu_rm_resp", 32'(fpu.fpu_round_mode), 32'd1);
        retire;

        // sqrt(-1.0): result one cycle after acceptance
        issue(32'hBF800000, 3'd0);
        pulse(0, 32'h7FC00000, 5'b10000);
        retire;

        // Watchdog timeout: no result pulse
        issue(32'h3F800000, 3'd0);
        cancel_cycles = 0;
        first_cancel  = 0;
        for (int k = 1; k <= 64; k++) begin
            #1;
            if (fpu.fpu_cancel === 1'b1) begin
                cancel_cycles++;
                if (first_cancel == 0) first_cancel = k;
            end
            step;
        end
        #1;
        chk("to_cancel_count", 32'(cancel_cycles), 32'd1);
        chk("to_cancel_cycle", 32'(first_cancel), 32'd64);
        chk("to_rsp_valid", 32'(host.rsp_valid), 32'd1);
        chk("to_rsp_result", host.rsp_result, 32'h7FC00000);
        chk("to_rsp_exc", 32'(host.rsp_exceptions), 32'd0);
        chk("to_rsp_timeout", 32'(host.rsp_timeout), 32'd1);
        chk("to_cancel_in_resp", 32'(fpu.fpu_cancel), 32'd0);
        retire;

        // Result on the terminal watchdog cycle wins
        issue(32'h3F800000, 3'd0);
        repeat (63) step;
        pulse(0, 32'h3F800000, 5'b00000);
        retire;

        // Abort at WAIT cycle 5
        issue(32'h3F800000, 3'd0);
        repeat (4) step;
        host.abort = 1'b1;
        #1;
        chk("abort_cancel", 32'(fpu.fpu_cancel), 32'd1);
        step;
        host.abort = 1'b0;
        #1;
        chk("abort_busy", 32'(host.busy), 32'd0);
        chk("abort_no_rsp", 32'(host.rsp_valid), 32'd0);
        chk("abort_cancel_drop", 32'(fpu.fpu_cancel), 32'd0);
        fpu.fpu_out_valid = 1'b1;
        step;
        fpu.fpu_out_valid = 1'b0;
        #1;
        chk("idle_pulse_ignored", 32'(host.rsp_valid), 32'd0);
        chk("idle_pulse_busy", 32'(host.busy), 32'd0);
        issue(32'h41100000, 3'd0);
        pulse(3, 32'h40400000, 5'b00000);
        retire;

        // Abort in IDLE blocks acceptance
        host.abort = 1'b1;
        host.req_valid = 1'b1;
        host.req_operand = 32'h40800000;
        #1;
        chk("idle_abort_req_ready", 32'(host.req_ready), 32'd0);
        step;
        host.abort = 1'b0;
        host.req_valid = 1'b0;
        #1;
        chk("idle_abort_busy", 32'(host.busy), 32'd0);

        // Backpressure: rsp_ready low for 10 cycles
        issue(32'h40800000, 3'd0);
        pulse(2, 32'h40000000, 5'b00000);
        for (int i = 0; i < 9; i++) begin
            step;
            chk("bp_rsp_valid", 32'(host.rsp_valid), 32'd1);
            chk("bp_rsp_result", host.rsp_result, 32'h40000000);
            chk("bp_req_ready", 32'(host.req_ready), 32'd0);
        end
        host.rsp_ready = 1'b1;
        #1;
        chk("bp_req_ready_pre", 32'(host.req_ready), 32'd0);
        step;
        host.rsp_ready = 1'b0;
        #1;
        chk("bp_req_ready_post", 32'(host.req_ready), 32'd1);

        // Abort in RESP drops the response
        issue(32'hBF800000, 3'd0);
        pulse(0, 32'h7FC00000, 5'b10000);
        host.abort = 1'b1;
        #1;
        chk("resp_abort_no_cancel", 32'(fpu.fpu_cancel), 32'd0);
        step;
        host.abort = 1'b0;
        #1;
        chk("resp_abort_rsp_valid", 32'(host.rsp_valid), 32'd0);
        chk("resp_abort_busy", 32'(host.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
